fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 80 ++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, PC redirect and decoder output.
// master = fetch unit side, slave = memory/decoder/branch environment side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;

  // Handshakes: a request transfers when imem_req_valid & imem_req_ready in the same cycle;
  // an instruction transfers when out_valid & out_ready; responses have no back-pressure.
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with a one-entry output register and
// redirect-driven kill of the in-flight fetch.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus,
  output logic          dbg_state,
  output logic          dbg_kill
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] inflight_pc;
  logic        kill;
  logic        accept;

  // A new fetch may only be issued when the output slot is free or drains this cycle.
  assign bus.imem_req_valid = rst & (state == S_REQ) & (!bus.out_valid | bus.out_ready);
  assign bus.imem_req_addr  = pc;
  assign accept             = bus.imem_req_valid & bus.imem_req_ready;

  assign dbg_state = (state == S_WAIT);
  assign dbg_kill  = kill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_REQ;
      pc            <= RESET_PC;
      inflight_pc   <= '0;
      kill          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_inst  <= 32'h0000_0013;
      bus.out_pc    <= '0;
    end else if (bus.redirect_valid) begin
      pc            <= bus.redirect_pc & ~64'h3;
      bus.out_valid <= 1'b0;
      if (state == S_REQ) begin
        // The old-pc request still goes out; its response is marked for discard.
        if (accept) begin
          inflight_pc <= pc;
          state       <= S_WAIT;
          kill        <= 1'b1;
        end
      end else if (bus.imem_rsp_valid) begin
        kill  <= 1'b0;
        state <= S_REQ;
      end else begin
        kill <= 1'b1;
      end
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (state == S_REQ) begin
        if (accept) begin
          inflight_pc <= pc;
          state       <= S_WAIT;
        end
      end else if (bus.imem_rsp_valid) begin
        state <= S_REQ;
        if (kill) begin
          kill <= 1'b0;
        end else begin
          bus.out_valid <= 1'b1;
          bus.out_inst  <= bus.imem_rsp_data;
          bus.out_pc    <= inflight_pc;
          pc            <= inflight_pc + 64'd4;
        end
      end
    end
  end

endmodule
